data_memory_responder: RTL and testbench

//   Memory-side responder for core load/store traffic.
//   - Accepts one word-aligned request at a time over a valid/ready channel.
//   - Applies the byte enables to an internal word RAM.
//   - Returns a read word or write acknowledge after a fixed latency, over a

---
 rtl/dmem_pkg.sv | 42 ++++
 rtl/dmem_byte_ram.sv | 34 +++
 rtl/data_memory_responder.sv | 173 +++++++++++++++++
 tb/tb_data_memory_responder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory responder.
// Also supplies the default data window (`DATA_BEGIN / `DATA_END). The window
// is only consulted when DATA_MEM_RANGE_CHECK_EN is defined.
`ifndef DATA_BEGIN
`define DATA_BEGIN 32'h0000_0000
`endif
`ifndef DATA_END
`define DATA_END 32'h0000_7FFC
`endif

package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  typedef struct packed {
    logic        write;
    logic [31:0] address;
    logic [3:0]  byteena;
    logic [31:0] wdata;
  } dmem_req_t;

  localparam int DMEM_MAX_LATENCY = 32'sd15;

  // True when a byte address lies inside the inclusive window [lo, hi].
  function automatic logic dmem_in_range(input logic [31:0] addr,
                                         input logic [31:0] lo,
                                         input logic [31:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

  // Lane enables actually applied to the RAM: all lanes are dropped when
  // the store is not allowed.
  function automatic logic [3:0] dmem_lane_mask(input logic [3:0] byteena,
                                                input logic       allow);
    return allow ? byteena : 4'b0000;
  endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Single-port 32-bit word RAM with four byte-lane write enables.
// The write is synchronous. The read is registered, and returns the word as
// it was before any write on the same edge. The RAM has no reset, so its
// contents survive a responder reset.
module dmem_byte_ram #(
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clock,
  input  logic                  read_en,
  input  logic [3:0]            byte_we,
  input  logic [ADDR_WIDTH-1:0] word_addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  localparam int DEPTH  = 32'sd1 << ADDR_WIDTH;
  localparam int LANES  = 32'sd4;
  localparam int LANE_W = 32'sd8;

  logic [31:0] mem [0:DEPTH-1];

  // Byte-lane write and registered read-before-write of the addressed word.
  always_ff @(posedge clock) begin
    for (int b = 0; b < LANES; b++) begin
      if (byte_we[b]) begin
        mem[word_addr][LANE_W*b +: LANE_W] <= wdata[LANE_W*b +: LANE_W];
      end
    end
    if (read_en) begin
      rdata <= mem[word_addr];
    end
  end

endmodule

// File: rtl/data_memory_responder.sv
// Memory-side responder for core load/store traffic. It accepts one request
// at a time and applies stores at the accepting edge. Each request is answered
// after a fixed LATENCY, with the response held until the initiator takes it.
// Optional feature: define DATA_MEM_RANGE_CHECK_EN to flag accesses outside
// [`DATA_BEGIN, `DATA_END]. Flagged accesses get rsp_error = 1 and rsp_rdata
// = 0, and their stores are suppressed.
module data_memory_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 13,
  parameter int LATENCY    = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_address,
  input  logic [3:0]  req_byteena,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int               CNT_W    = $clog2(DMEM_MAX_LATENCY + 32'sd1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 32'sd1);

  dmem_state_t      state_r;
  dmem_state_t      state_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_s;

  dmem_req_t        req_s;
  logic             accept_s;
  logic             in_range_s;
  logic [3:0]       byte_we_s;
  logic             read_en_s;
  logic [31:0]      ram_rdata_s;

  logic             op_write_r;
  logic             op_error_r;
  logic             rsp_valid_r;
  logic [31:0]      rsp_rdata_r;
  logic             rsp_error_r;

  // Word-offset bits and wrapped-away upper address bits are intentionally unused.
  logic             unused_bits_s;

  assign req_s = '{write:   req_write,
                   address: req_address,
                   byteena: req_byteena,
                   wdata:   req_wdata};

  assign req_ready = reset_n & (state_r == IDLE);
  assign accept_s  = req_valid & req_ready;

`ifdef DATA_MEM_RANGE_CHECK_EN
  assign in_range_s = dmem_in_range(req_s.address, `DATA_BEGIN, `DATA_END);
`else
  assign in_range_s = 1'b1;
`endif

  assign byte_we_s = dmem_lane_mask(req_s.byteena, accept_s & req_s.write & in_range_s);
  assign read_en_s = accept_s & ~req_s.write;

  assign unused_bits_s = ^{req_s.address[1:0], req_s.address[31:ADDR_WIDTH+2]};

  dmem_byte_ram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clock     (clock),
    .read_en   (read_en_s),
    .byte_we   (byte_we_s),
    .word_addr (req_s.address[ADDR_WIDTH+1:2]),
    .wdata     (req_s.wdata),
    .rdata     (ram_rdata_s)
  );

  // Next-state and latency-counter logic for the request/response sequence.
  always_comb begin
    state_s = state_r;
    count_s = count_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (LATENCY == 32'sd1) begin
            state_s = RESP;
            count_s = CNT_ZERO;
          end else begin
            state_s = WAIT;
            count_s = CNT_LOAD;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        count_s = count_r - CNT_ONE;
        if (count_r == CNT_ONE) begin
          state_s = RESP;
        end else begin
          state_s = WAIT;
        end
      end
      RESP: begin
        if (rsp_valid_r && rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
        count_s = CNT_ZERO;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r <= IDLE;
      count_r <= CNT_ZERO;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
    end
  end

  // Remember the kind of the accepted access so the response can be formed later.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      op_write_r <= 1'b0;
      op_error_r <= 1'b0;
    end else if (accept_s) begin
      op_write_r <= req_s.write;
      op_error_r <= ~in_range_s;
    end
  end

  // Response register: it is loaded one edge after RESP is entered, held
  // stable under backpressure, and cleared when the response is taken.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_error_r <= 1'b0;
    end else if (state_r == RESP) begin
      if (rsp_valid_r && rsp_ready) begin
        rsp_valid_r <= 1'b0;
        rsp_rdata_r <= 32'h0000_0000;
        rsp_error_r <= 1'b0;
      end else if (!rsp_valid_r) begin
        rsp_valid_r <= 1'b1;
        rsp_rdata_r <= (op_write_r || op_error_r) ? 32'h0000_0000 : ram_rdata_s;
        rsp_error_r <= op_error_r;
      end
    end else begin
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_error_r <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_error = rsp_error_r;

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder (LATENCY = 3).
// A behavioural word-array model predicts every response. The bench runs
// directed scenarios (basic store/load, byte lanes, timing, backpressure,
// reset mid-request, aliasing/range) followed by a randomized traffic phase.
`ifndef DATA_BEGIN
`define DATA_BEGIN 32'h0000_0000
`endif
`ifndef DATA_END
`define DATA_END 32'h0000_7FFC
`endif

module tb_data_memory_responder;

  localparam int AW    = 13;
  localparam int LAT   = 3;
  localparam int DEPTH = 1 << AW;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_address;
  logic [3:0]  req_byteena;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [int];

  always #5 clock = ~clock;

  data_memory_responder #(
    .ADDR_WIDTH (AW),
    .LATENCY    (LAT)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_address (req_address),
    .req_byteena (req_byteena),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_error   (rsp_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit out_of_range(input logic [31:0] a);
`ifdef DATA_MEM_RANGE_CHECK_EN
    return (a < `DATA_BEGIN) || (a > `DATA_END);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a / 4) % DEPTH;
  endfunction

  // Reference behaviour: apply the request to the word array and predict the response.
  task automatic model_req(input logic w, input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] wd, output logic [31:0] erd,
                           output logic eer, output bit known);
    int i;
    logic [31:0] word;
    i = widx(a);
    eer = out_of_range(a);
    known = 1'b1;
    erd = 32'h0;
    if (eer) begin
      erd = 32'h0;
    end else if (w) begin
      word = model.exists(i) ? model[i] : 32'h0;
      for (int b = 0; b < 4; b++) begin
        if (be[b]) word[8*b +: 8] = wd[8*b +: 8];
      end
      model[i] = word;
    end else begin
      known = model.exists(i);
      erd = known ? model[i] : 32'h0;
    end
  endtask

  // One complete transaction, with timing, stability and value checks along the way.
  task automatic transact(input string tag, input logic w, input logic [31:0] a,
                          input logic [3:0] be, input logic [31:0] wd, input int stall,
                          output logic [31:0] rd, output logic er);
    int n;
    logic [31:0] erd;
    logic eer;
    bit known;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(posedge clock); #1; n++;
    end
    chk({tag, "_ready_wait"}, 32'(n < 50), 32'd1);
    req_valid = 1'b1; req_write = w; req_address = a; req_byteena = be; req_wdata = wd;
    rsp_ready = (stall == 0);
    @(posedge clock); #1;
    model_req(w, a, be, wd, erd, eer, known);
    req_valid = 1'b0; req_write = 1'($urandom); req_address = $urandom;
    req_byteena = 4'($urandom); req_wdata = $urandom;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin
      chk({tag, "_busy"}, {31'd0, req_ready}, 32'd0);
      if (stall != 0) rsp_ready = 1'($urandom_range(0, 1));
      @(posedge clock); #1; n++;
    end
    chk({tag, "_latency"}, n, LAT);
    chk({tag, "_busy_resp"}, {31'd0, req_ready}, 32'd0);
    rd = rsp_rdata;
    er = rsp_error;
    if (known) chk({tag, "_rdata"}, rd, erd);
    chk({tag, "_error"}, {31'd0, er}, {31'd0, eer});
    if (stall != 0) begin
      rsp_ready = 1'b0;
      for (int s = 0; s < stall; s++) begin
        @(posedge clock); #1;
        chk({tag, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
        chk({tag, "_hold_rdata"}, rsp_rdata, rd);
        chk({tag, "_hold_error"}, {31'd0, rsp_error}, {31'd0, er});
      end
      rsp_ready = 1'b1;
    end
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    chk({tag, "_done_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_done_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  logic [31:0] rd;
  logic        er;
  logic [31:0] pool [8];
  logic [31:0] a_base;
  logic [31:0] a_alias;
  logic [31:0] a_rst;
  logic [31:0] erd_r;
  logic        eer_r;
  bit          known_r;

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_address = 32'h0;
    req_byteena = 4'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
    a_base  = `DATA_BEGIN + 32'h10;
    a_alias = `DATA_END + 32'h4;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_error", {31'd0, rsp_error}, 32'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

    // Full-word store then load; rsp_ready held high gives the base timing
    transact("st_full", 1'b1, a_base, 4'b1111, 32'hDEADBEEF, 0, rd, er);
    chk("st_full_ack", rd, 32'h0);
    transact("ld_full", 1'b0, a_base, 4'b0000, 32'h0, 0, rd, er);
    chk("ld_full_val", rd, 32'hDEADBEEF);
    chk("ld_full_err", {31'd0, er}, 32'd0);

    // Single-lane store, then a store with no lanes enabled
    transact("st_lane2", 1'b1, a_base, 4'b0100, 32'h00AA0000, 0, rd, er);
    transact("ld_lane2", 1'b0, a_base, 4'b1111, 32'h0, 0, rd, er);
    chk("ld_lane2_val", rd, 32'hDEAABEEF);
    transact("st_none", 1'b1, a_base, 4'b0000, 32'hFFFFFFFF, 0, rd, er);
    transact("ld_none", 1'b0, a_base, 4'b0000, 32'h0, 0, rd, er);
    chk("ld_none_val", rd, 32'hDEAABEEF);

    // Backpressure: response held for five cycles
    transact("bp", 1'b0, a_base, 4'b0000, 32'h0, 5, rd, er);
    chk("bp_val", rd, 32'hDEAABEEF);

    // Reset while waiting drops the response; the store has already committed
    a_rst = `DATA_BEGIN + 32'h200;
    chk("rst_mid_ready_pre", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = 1'b1; req_address = a_rst;
    req_byteena = 4'b1111; req_wdata = 32'h12345678; rsp_ready = 1'b1;
    @(posedge clock); #1;
    model_req(1'b1, a_rst, 4'b1111, 32'h12345678, erd_r, eer_r, known_r);
    req_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_ready_low", {31'd0, req_ready}, 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      chk("rst_mid_no_rsp", {31'd0, rsp_valid}, 32'd0);
      @(posedge clock); #1;
    end
    rsp_ready = 1'b0;
    transact("ld_after_rst", 1'b0, a_rst, 4'b0000, 32'h0, 0, rd, er);
    chk("ld_after_rst_val", rd, 32'h12345678);

    // Aliasing / range check on `DATA_END+4, which wraps to word 0
    transact("st_word0", 1'b1, `DATA_BEGIN, 4'b1111, 32'h11111111, 0, rd, er);
    transact("st_alias", 1'b1, a_alias, 4'b1111, 32'hCAFEF00D, 1, rd, er);
`ifdef DATA_MEM_RANGE_CHECK_EN
    chk("st_alias_err", {31'd0, er}, 32'd1);
    transact("ld_word0", 1'b0, `DATA_BEGIN, 4'b0000, 32'h0, 0, rd, er);
    chk("ld_word0_val", rd, 32'h11111111);
`else
    chk("st_alias_err", {31'd0, er}, 32'd0);
    transact("ld_word0", 1'b0, `DATA_BEGIN, 4'b0000, 32'h0, 0, rd, er);
    chk("ld_word0_val", rd, 32'hCAFEF00D);
`endif

    // Randomized traffic over a small address pool
    pool[0] = `DATA_BEGIN + 32'h10;  pool[1] = `DATA_BEGIN + 32'h14;
    pool[2] = `DATA_BEGIN + 32'h100; pool[3] = `DATA_END;
    pool[4] = `DATA_END - 32'h4;     pool[5] = `DATA_BEGIN;
    pool[6] = `DATA_END + 32'h4;     pool[7] = 32'h0001_2344;
    for (int p = 0; p < 8; p++) begin
      transact("rnd_init", 1'b1, pool[p] | 32'($urandom_range(0, 3)), 4'b1111, $urandom,
               0, rd, er);
    end
    for (int t = 0; t < 40; t++) begin
      transact("rnd", 1'($urandom), pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3)),
               4'($urandom), $urandom, $urandom_range(0, 3), rd, er);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
